uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
Parametrised UART frame transmitter. It is the successor to the fixed 8N1 byte transmitter in the rtc_uart subsystem.
- Adds runtime-programmable baud divisor, data length 5..DATA_W, parity (none/even/odd) and 1 or 2 stop bits.
- Uses a valid/ready handshake instead of a level-sensitive send enable.
- Sits between the RTC/command formatter and the tx pad; config comes from the UART control register.

Parameters:
DIV_W, 16, width of baud divisor; bit period = baud_div+1 clk cycles
DATA_W, 8, maximum data bits per frame; legal 5..9

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_valid  in  1  frame request; data/config valid while high
tx_ready  out  1  high when block can accept a frame (state IDLE)
tx_data  in  DATA_W  payload, LSB transmitted first; bits above data_len ignored
data_len  in  4  number of data bits; <5 clamps to 5, >DATA_W clamps to DATA_W
parity_mode  in  2  0=none, 1=even, 2=odd, 3=treated as none
stop2  in  1  0=one stop bit, 1=two stop bits
baud_div  in  DIV_W  cycles per bit minus 1; 0 legal (1 cycle/bit)
uart_tx  out  1  serial line, idle high
busy  out  1  high from accept cycle+1 through last stop bit
tx_done  out  1  one-cycle pulse after last stop bit completes

Behaviour:
- Reset (synchronous, sampled at posedge clk while rst=1):
  - uart_tx=1, busy=0, tx_done=0, state=IDLE, all counters 0.
  - rst asserted mid-frame aborts at the next edge: line returns high, no tx_done.
- Handshake and config capture:
  - Accept occurs at the posedge where tx_valid && tx_ready.
  - tx_ready = (state==IDLE), driven combinationally from registered state.
  - tx_data, data_len (post-clamp), parity_mode, stop2 and baud_div are all registered at accept.
  - Input changes during a frame have no effect.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when none) -> STOP -> IDLE.
  - Each state holds for whole bit periods of baud_div_q+1 cycles, timed by bit_tick from the baud generator.
  - DATA holds for data_len_q bit periods; bit index 0..data_len_q-1, LSB first.
  - STOP holds 1 or 2 bit periods per stop2_q.
- Line values: START=0; DATA=data_q[idx]; PARITY as below; STOP=1; IDLE=1.
  - uart_tx is registered; first start-bit cycle is the cycle after the accept edge.
- Parity: even = XOR of the data_len_q transmitted bits; odd = inverse of that.
- Frame length: (1 + data_len_q + (parity?1:0) + (stop2?2:1)) * (baud_div_q+1) cycles.
- Completion:
  - The edge ending the last stop period moves state to IDLE; in that first IDLE cycle tx_done=1, tx_ready=1, busy=0.
  - Back-to-back: if tx_valid is high in that cycle, the next frame is accepted at that edge. The line stays high exactly one cycle between frames.
- Baud counter:
  - Cleared at accept; counts 0..baud_div_q; bit_tick fires when count==baud_div_q, then wraps to 0.
  - Counter is held at 0 in IDLE.
- tx_valid deasserted without acceptance has no effect.
- Counter widths: bit index 4 bits; stop counter 1 bit. No wrap occurs beyond DATA_W.

Decomposition:
- Package uart_pkg:
  - parity_mode encoding constants (PAR_NONE/EVEN/ODD).
  - FSM state enum.
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - DATA_W_MIN=5.
- Sub-module uart_baud_gen (DIV_W):
  - Inputs: clk, rst, clr, en, div.
  - Output: bit_tick.
  - Reusable by the future parametrised receiver.

Test Plan:
- baud_div=3, len=8, none, stop2=0, tx_data=0xA5, accept at edge 0:
  - cycles 1-4 line=0.
  - data 1,0,1,0,0,1,0,1 in 4-cycle slots (cycles 5-36).
  - stop cycles 37-40 =1.
  - tx_done=1 only at cycle 41; busy 1..40.
- baud_div=0, len=7, even parity, tx_data=0x03: line 0,1,1,0,0,0,0,0,0,1 on consecutive cycles; tx_done 1 cycle after.
- Odd parity, len=5, stop2=1, tx_data=0xFF:
  - only 5 ones sent; parity bit=0.
  - two stop periods.
  - frame = 9 bit periods.
- data_len=2 clamps to 5; data_len=15 clamps to DATA_W (8).
  - Frame lengths measured as 7 and 10 bit periods (no parity, 1 stop).
- tx_valid held high continuously for 3 frames:
  - accepts occur only when tx_ready=1.
  - exactly one idle-high cycle between frames.
  - three tx_done pulses.
  - changing tx_data mid-frame does not alter the serial output.
- rst=1 for one cycle during DATA bit 3: next cycle uart_tx=1, busy=0, tx_ready=1, no tx_done; a subsequent frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame transmitter and the future receiver.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam int unsigned DATA_W_MIN = 5;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div and pulses bit_tick on the last cycle of each period.
module uart_baud_gen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick
);

   logic [DIV_W-1:0] r_cnt;

   assign bit_tick = en && (r_cnt == div);

   // Held at zero while disabled so every frame starts on a fresh period.
   always_ff @(posedge clk) begin
      if (rst || clr || !en) begin
         r_cnt <= '0;
      end else if (bit_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Configurable UART frame transmitter: start, 5..DATA_W data bits LSB first,
// optional parity, one or two stop bits, with a valid/ready request interface.
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [3:0]        data_len,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   input  logic [DIV_W-1:0]  baud_div,
   output logic              uart_tx,
   output logic              busy,
   output logic              tx_done
);

   uart_state_t       r_state;
   logic [DATA_W-1:0] r_data;
   logic [3:0]        r_len;
   logic [3:0]        r_idx;
   logic [1:0]        r_par_mode;
   logic              r_stop2;
   logic              r_stop_cnt;
   logic [DIV_W-1:0]  r_div;

   logic              w_accept;
   logic              w_bit_tick;
   logic [3:0]        w_len;
   logic [3:0]        w_next_idx;
   logic [DATA_W-1:0] w_masked;
   logic [DATA_W-1:0] w_shifted;
   logic              w_next_bit;
   logic              w_par_en;
   logic              w_par_bit;

   assign tx_ready = (r_state == ST_IDLE);
   assign w_accept = tx_valid && tx_ready;

   always_comb begin
      if (data_len < 4'(DATA_W_MIN)) begin
         w_len = 4'(DATA_W_MIN);
      end else if (data_len > 4'(DATA_W)) begin
         w_len = 4'(DATA_W);
      end else begin
         w_len = data_len;
      end
   end

   // Parity covers only the bits that actually go out on the line.
   always_comb begin
      w_masked = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_masked[i] = r_data[i] && (4'(i) < r_len);
      end
   end

   assign w_par_en   = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
   assign w_par_bit  = (^w_masked) ^ (r_par_mode == PAR_ODD);
   assign w_next_idx = r_idx + 4'd1;
   assign w_shifted  = r_data >> w_next_idx;
   assign w_next_bit = w_shifted[0];

   uart_baud_gen #(
      .DIV_W (DIV_W)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_accept),
      .en       (r_state != ST_IDLE),
      .div      (r_div),
      .bit_tick (w_bit_tick)
   );

   // The line value for the next bit period is loaded on the edge that enters it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_data     <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_par_mode <= PAR_NONE;
         r_stop2    <= 1'b0;
         r_stop_cnt <= 1'b0;
         r_div      <= '0;
         uart_tx    <= IDLE_LEVEL;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (tx_valid) begin
                  r_data     <= tx_data;
                  r_len      <= w_len;
                  r_par_mode <= parity_mode;
                  r_stop2    <= stop2;
                  r_div      <= baud_div;
                  r_idx      <= '0;
                  r_stop_cnt <= 1'b0;
                  uart_tx    <= START_BIT;
                  busy       <= 1'b1;
                  r_state    <= ST_START;
               end
            end
            ST_START: begin
               if (w_bit_tick) begin
                  uart_tx <= r_data[0];
                  r_idx   <= '0;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bit_tick) begin
                  if (w_next_idx == r_len) begin
                     if (w_par_en) begin
                        uart_tx <= w_par_bit;
                        r_state <= ST_PARITY;
                     end else begin
                        uart_tx <= STOP_BIT;
                        r_state <= ST_STOP;
                     end
                  end else begin
                     r_idx   <= w_next_idx;
                     uart_tx <= w_next_bit;
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_tick) begin
                  uart_tx <= STOP_BIT;
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_bit_tick) begin
                  if (r_stop2 && !r_stop_cnt) begin
                     r_stop_cnt <= 1'b1;
                  end else begin
                     r_stop_cnt <= 1'b0;
                     uart_tx    <= IDLE_LEVEL;
                     busy       <= 1'b0;
                     tx_done    <= 1'b1;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            default: begin
               uart_tx <= IDLE_LEVEL;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx against a per-cycle line model built from frame rules.
module tb_uart_frame_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic [3:0]  data_len;
   logic [1:0]  parity_mode;
   logic        stop2;
   logic [15:0] baud_div;
   logic        uart_tx;
   logic        busy;
   logic        tx_done;

   int checks = 0;
   int fails  = 0;

   bit   exp_line[$];
   logic obs_line[$];
   logic obs_busy[$];
   logic obs_done[$];
   logic obs_ready[$];

   uart_frame_tx #(.DIV_W(16), .DATA_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .data_len    (data_len),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .baud_div    (baud_div),
      .uart_tx     (uart_tx),
      .busy        (busy),
      .tx_done     (tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected per-cycle line levels of one frame; returns its length in cycles.
   function automatic int model_frame(input logic [7:0] d, input int len, input int pm,
                                      input bit s2, input int div);
      bit bits[$];
      int n;
      int ones;
      n    = (len < 5) ? 5 : ((len > 8) ? 8 : len);
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pm == 1) bits.push_back(bit'(ones % 2));
      if (pm == 2) bits.push_back(bit'((ones + 1) % 2));
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      exp_line.delete();
      foreach (bits[b]) begin
         for (int c = 0; c <= div; c++) exp_line.push_back(bits[b]);
      end
      return exp_line.size();
   endfunction

   task automatic clear_obs();
      obs_line.delete();
      obs_busy.delete();
      obs_done.delete();
      obs_ready.delete();
   endtask

   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         obs_line.push_back(uart_tx);
         obs_busy.push_back(busy);
         obs_done.push_back(tx_done);
         obs_ready.push_back(tx_ready);
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (tx_ready !== 1'b1 && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      checks++;
      if (tx_ready !== 1'b1) begin
         fails++;
         $display("FAIL wait_ready: tx_ready=%b after %0d cycles, required 1", tx_ready, t);
      end
   endtask

   task automatic drive_cfg(input logic [7:0] d, input int len, input int pm,
                            input bit s2, input int div);
      tx_data     = d;
      data_len    = 4'(len);
      parity_mode = 2'(pm);
      stop2       = s2;
      baud_div    = 16'(div);
   endtask

   // Launches one frame and leaves the bench in the first cycle after the accept edge.
   task automatic start_frame(input logic [7:0] d, input int len, input int pm,
                              input bit s2, input int div, output int frame_len);
      wait_ready();
      drive_cfg(d, len, pm, s2, div);
      tx_valid  = 1'b1;
      frame_len = model_frame(d, len, pm, s2, div);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      drive_cfg(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      clear_obs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_line: got %b required 1", uart_tx); end
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", tx_done); end
      checks++;
      if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({uart_tx, busy, tx_done} !== 3'b100) begin
         fails++;
         $display("FAIL idle_hold: line/busy/done=%b required 100", {uart_tx, busy, tx_done});
      end
   endtask

   task automatic test_vectors();
      logic [7:0] v_data[5] = '{8'hA5, 8'h03, 8'hFF, 8'h5A, 8'hC3};
      int         v_len[5]  = '{8, 7, 5, 2, 15};
      int         v_pm[5]   = '{0, 1, 2, 0, 0};
      bit         v_s2[5]   = '{0, 0, 1, 0, 0};
      int         v_div[5]  = '{3, 0, 1, 2, 1};
      int         v_per[5]  = '{10, 10, 9, 7, 10};
      int         flen;
      int         nbusy;
      for (int v = 0; v < 5; v++) begin
         start_frame(v_data[v], v_len[v], v_pm[v], v_s2[v], v_div[v], flen);
         capture(flen + 1);
         nbusy = 0;
         for (int k = 0; k < flen; k++) begin
            checks++;
            if (obs_line[k] !== exp_line[k]) begin
               fails++;
               $display("FAIL vec%0d_line cyc %0d: got %b required %b", v, k + 1, obs_line[k], exp_line[k]);
            end
            checks++;
            if ({obs_busy[k], obs_done[k]} !== 2'b10) begin
               fails++;
               $display("FAIL vec%0d_busy_done cyc %0d: got %b required 10", v, k + 1, {obs_busy[k], obs_done[k]});
            end
            if (obs_busy[k] === 1'b1) nbusy++;
         end
         checks++;
         if ({obs_line[flen], obs_busy[flen], obs_done[flen], obs_ready[flen]} !== 4'b1011) begin
            fails++;
            $display("FAIL vec%0d_end line/busy/done/ready: got %b required 1011", v,
                     {obs_line[flen], obs_busy[flen], obs_done[flen], obs_ready[flen]});
         end
         checks++;
         if (nbusy !== v_per[v] * (v_div[v] + 1)) begin
            fails++;
            $display("FAIL vec%0d_length: got %0d cycles required %0d", v, nbusy, v_per[v] * (v_div[v] + 1));
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      int len, pm, div, flen;
      bit s2;
      for (int f = 0; f < 12; f++) begin
         d    = 8'($urandom);
         len  = int'($urandom_range(0, 15));
         pm   = int'($urandom_range(0, 3));
         s2   = bit'($urandom_range(0, 1));
         div  = int'($urandom_range(0, 4));
         start_frame(d, len, pm, s2, div, flen);
         capture(flen + 1);
         for (int k = 0; k < flen; k++) begin
            checks++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], 2'b10}) begin
               fails++;
               $display("FAIL rand%0d cyc %0d line/busy/done: got %b required %b", f, k + 1,
                        {obs_line[k], obs_busy[k], obs_done[k]}, {exp_line[k], 2'b10});
            end
         end
         checks++;
         if ({obs_line[flen], obs_busy[flen], obs_done[flen]} !== 3'b101) begin
            fails++;
            $display("FAIL rand%0d_end line/busy/done: got %b required 101", f,
                     {obs_line[flen], obs_busy[flen], obs_done[flen]});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d[3];
      int len[3], pm[3], div[3], flen[3];
      bit s2[3];
      bit exp_all[$];
      bit exp_gap[$];
      int ndone;
      for (int f = 0; f < 3; f++) begin
         d[f]   = 8'($urandom);
         len[f] = int'($urandom_range(5, 8));
         pm[f]  = int'($urandom_range(0, 2));
         s2[f]  = bit'($urandom_range(0, 1));
         div[f] = int'($urandom_range(0, 2));
         flen[f] = model_frame(d[f], len[f], pm[f], s2[f], div[f]);
         foreach (exp_line[k]) begin
            exp_all.push_back(exp_line[k]);
            exp_gap.push_back(1'b0);
         end
         exp_all.push_back(1'b1);
         exp_gap.push_back(1'b1);
      end
      wait_ready();
      drive_cfg(d[0], len[0], pm[0], s2[0], div[0]);
      tx_valid = 1'b1;
      @(posedge clk); #1;
      clear_obs();
      drive_cfg(d[1], len[1], pm[1], s2[1], div[1]);
      capture(flen[0] + 1);
      drive_cfg(d[2], len[2], pm[2], s2[2], div[2]);
      capture(flen[1] + 1);
      tx_valid = 1'b0;
      drive_cfg(~d[2], 8, 1, 1'b1, 5);
      capture(flen[2] + 1);
      ndone = 0;
      foreach (exp_all[k]) begin
         checks++;
         if ({obs_line[k], obs_done[k], obs_ready[k], obs_busy[k]} !==
             {exp_all[k], exp_gap[k], exp_gap[k], !exp_gap[k]}) begin
            fails++;
            $display("FAIL b2b cyc %0d line/done/ready/busy: got %b required %b", k + 1,
                     {obs_line[k], obs_done[k], obs_ready[k], obs_busy[k]},
                     {exp_all[k], exp_gap[k], exp_gap[k], !exp_gap[k]});
         end
         if (obs_done[k] === 1'b1) ndone++;
      end
      checks++;
      if (ndone !== 3) begin
         fails++;
         $display("FAIL b2b_done_count: got %0d required 3", ndone);
      end
      checks++;
      if ({busy, tx_ready} !== 2'b01) begin
         fails++;
         $display("FAIL b2b_no_extra_accept busy/ready: got %b required 01", {busy, tx_ready});
      end
   endtask

   task automatic test_reset_abort();
      int flen;
      int nbad;
      start_frame(8'hA5, 8, 0, 1'b0, 3, flen);
      repeat (17) begin @(posedge clk); #1; end
      checks++;
      if ({uart_tx, busy} !== 2'b01) begin
         fails++;
         $display("FAIL abort_pre line/busy in data bit 3: got %b required 01", {uart_tx, busy});
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({uart_tx, busy, tx_ready, tx_done} !== 4'b1010) begin
         fails++;
         $display("FAIL abort line/busy/ready/done: got %b required 1010", {uart_tx, busy, tx_ready, tx_done});
      end
      clear_obs();
      capture(8);
      nbad = 0;
      foreach (obs_line[k]) if ({obs_line[k], obs_busy[k], obs_done[k]} !== 3'b100) nbad++;
      checks++;
      if (nbad !== 0) begin
         fails++;
         $display("FAIL abort_quiet: %0d cycles off idle, required 0", nbad);
      end
      start_frame(8'h3C, 6, 2, 1'b1, 2, flen);
      capture(flen + 1);
      nbad = 0;
      for (int k = 0; k < flen; k++) if (obs_line[k] !== exp_line[k]) nbad++;
      checks++;
      if (nbad !== 0 || obs_done[flen] !== 1'b1) begin
         fails++;
         $display("FAIL abort_recover: %0d line errors, done=%b, required 0 errors and done=1", nbad, obs_done[flen]);
      end
   endtask

   initial begin
      rst         = 1'b1;
      tx_valid    = 1'b0;
      tx_data     = '0;
      data_len    = 4'd8;
      parity_mode = 2'd0;
      stop2       = 1'b0;
      baud_div    = '0;
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
